// File: rtl/pagerank_host_seq.sv
// Host-side softreg sequencer for PageRank: latches job parameters on start, writes the
//   eight-entry configuration, then polls DONE_ALL with bounded read retries.
// Latency: first write on the cycle after start; first read 8 + POLL_DELAY + 1 cycles after start.
// Backpressure: softreg has no ready; one request per cycle; start while busy is ignored.
//
// Ports:
//   clk, rst (async active-low)     - clock and reset
//   start, n_vert .. n_rounds       - job start pulse and the seven job parameters
//   softreg_req_*                   - registered request to PageRank, all zero when not valid
//   softreg_resp_valid/_data        - response from PageRank, honoured only while awaiting a read
//   busy, done, error               - job status; done/error are sticky until the next start
//   result, cycles                  - captured read data and elapsed cycles (start excluded)
module pagerank_host_seq #(
  parameter int POLL_DELAY   = 16,
  parameter int RESP_TIMEOUT = 1000000,  // must be at least 1
  parameter int MAX_RETRIES  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] n_vert,
  input  logic [63:0] n_inedges,
  input  logic [63:0] vaddr,
  input  logic [63:0] ieaddr,
  input  logic [63:0] write_addr0,
  input  logic [63:0] write_addr1,
  input  logic [63:0] n_rounds,
  output logic        softreg_req_valid,
  output logic        softreg_req_isWrite,
  output logic [31:0] softreg_req_addr,
  output logic [63:0] softreg_req_data,
  input  logic        softreg_resp_valid,
  input  logic [63:0] softreg_resp_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] result,
  output logic [31:0] cycles
);

  // PageRank softreg map (byte addresses, 8-byte registers).
  localparam logic [31:0] ADDR_N_VERT           = 32'h0000_0000;
  localparam logic [31:0] ADDR_N_INEDGES        = 32'h0000_0008;
  localparam logic [31:0] ADDR_VADDR            = 32'h0000_0010;
  localparam logic [31:0] ADDR_IEADDR           = 32'h0000_0018;
  localparam logic [31:0] ADDR_WRITE_ADDR0      = 32'h0000_0020;
  localparam logic [31:0] ADDR_WRITE_ADDR1      = 32'h0000_0028;
  localparam logic [31:0] ADDR_N_ROUNDS         = 32'h0000_0030;
  localparam logic [31:0] ADDR_DONE_READ_PARAMS = 32'h0000_0038;
  localparam logic [31:0] ADDR_DONE_ALL         = 32'h0000_0040;

  localparam logic [31:0] POLL_LAST = 32'(POLL_DELAY - 1);
  localparam logic [31:0] RESP_LAST = 32'(RESP_TIMEOUT - 1);
  localparam logic [31:0] RETRY_MAX = 32'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_POLL_WAIT,
    S_READ_REQ,
    S_READ_WAIT
  } state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [31:0] timer;
  logic [31:0] retries;
  logic [63:0] p_n_vert, p_n_inedges, p_vaddr, p_ieaddr;
  logic [63:0] p_write_addr0, p_write_addr1, p_n_rounds;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;

  // Address/data of configuration write number idx.
  always_comb begin
    wr_addr = ADDR_N_VERT;
    wr_data = p_n_vert;
    case (idx)
      3'd0: begin wr_addr = ADDR_N_VERT;           wr_data = p_n_vert;      end
      3'd1: begin wr_addr = ADDR_N_INEDGES;        wr_data = p_n_inedges;   end
      3'd2: begin wr_addr = ADDR_VADDR;            wr_data = p_vaddr;       end
      3'd3: begin wr_addr = ADDR_IEADDR;           wr_data = p_ieaddr;      end
      3'd4: begin wr_addr = ADDR_WRITE_ADDR0;      wr_data = p_write_addr0; end
      3'd5: begin wr_addr = ADDR_WRITE_ADDR1;      wr_data = p_write_addr1; end
      3'd6: begin wr_addr = ADDR_N_ROUNDS;         wr_data = p_n_rounds;    end
      default: begin wr_addr = ADDR_DONE_READ_PARAMS; wr_data = 64'd0;     end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= S_IDLE;
      idx                 <= 3'd0;
      timer               <= 32'd0;
      retries             <= 32'd0;
      p_n_vert            <= 64'd0;
      p_n_inedges         <= 64'd0;
      p_vaddr             <= 64'd0;
      p_ieaddr            <= 64'd0;
      p_write_addr0       <= 64'd0;
      p_write_addr1       <= 64'd0;
      p_n_rounds          <= 64'd0;
      softreg_req_valid   <= 1'b0;
      softreg_req_isWrite <= 1'b0;
      softreg_req_addr    <= 32'd0;
      softreg_req_data    <= 64'd0;
      busy                <= 1'b0;
      done                <= 1'b0;
      error               <= 1'b0;
      result              <= 64'd0;
      cycles              <= 32'd0;
    end else begin
      // Request lines are single-cycle strobes and idle at zero.
      softreg_req_valid   <= 1'b0;
      softreg_req_isWrite <= 1'b0;
      softreg_req_addr    <= 32'd0;
      softreg_req_data    <= 64'd0;

      // busy covers the cycle after start through the completing cycle.
      if (busy && cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;

      case (state)
        S_IDLE: begin
          if (start) begin
            p_n_vert      <= n_vert;
            p_n_inedges   <= n_inedges;
            p_vaddr       <= vaddr;
            p_ieaddr      <= ieaddr;
            p_write_addr0 <= write_addr0;
            p_write_addr1 <= write_addr1;
            p_n_rounds    <= n_rounds;
            done          <= 1'b0;
            error         <= 1'b0;
            result        <= 64'd0;
            cycles        <= 32'd0;
            busy          <= 1'b1;
            retries       <= 32'd0;
            // Write 0 is issued straight from the inputs so it lands on the next cycle.
            softreg_req_valid   <= 1'b1;
            softreg_req_isWrite <= 1'b1;
            softreg_req_addr    <= ADDR_N_VERT;
            softreg_req_data    <= n_vert;
            idx                 <= 3'd1;
            state               <= S_WRITE;
          end
        end
        S_WRITE: begin
          softreg_req_valid   <= 1'b1;
          softreg_req_isWrite <= 1'b1;
          softreg_req_addr    <= wr_addr;
          softreg_req_data    <= wr_data;
          idx                 <= idx + 3'd1;
          if (idx == 3'd7) begin
            timer <= 32'd0;
            state <= (POLL_DELAY == 0) ? S_READ_REQ : S_POLL_WAIT;
          end
        end
        S_POLL_WAIT: begin
          if (timer == POLL_LAST) state <= S_READ_REQ;
          else                    timer <= timer + 32'd1;
        end
        S_READ_REQ: begin
          softreg_req_valid <= 1'b1;
          softreg_req_addr  <= ADDR_DONE_ALL;
          timer             <= 32'd0;
          state             <= S_READ_WAIT;
        end
        S_READ_WAIT: begin
          // A response on the timeout cycle takes priority over the retry.
          if (softreg_resp_valid) begin
            result <= softreg_resp_data;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else if (timer == RESP_LAST) begin
            if (retries < RETRY_MAX) begin
              retries <= retries + 32'd1;
              state   <= S_READ_REQ;
            end else begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pagerank_host_seq.sv
module tb_pagerank_host_seq;

  localparam int PD = 16;
  localparam int T  = 10;
  localparam int MR = 3;

  localparam logic [31:0] A_IEADDR   = 32'h18;
  localparam logic [31:0] A_DONE_ALL = 32'h40;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] n_vert, n_inedges, vaddr, ieaddr, write_addr0, write_addr1, n_rounds;
  logic        softreg_req_valid, softreg_req_isWrite;
  logic [31:0] softreg_req_addr;
  logic [63:0] softreg_req_data;
  logic        softreg_resp_valid;
  logic [63:0] softreg_resp_data;
  logic        busy, done, error;
  logic [63:0] result;
  logic [31:0] cycles;

  pagerank_host_seq #(.POLL_DELAY(PD), .RESP_TIMEOUT(T), .MAX_RETRIES(MR)) dut (
    .clk(clk), .rst(rst), .start(start),
    .n_vert(n_vert), .n_inedges(n_inedges), .vaddr(vaddr), .ieaddr(ieaddr),
    .write_addr0(write_addr0), .write_addr1(write_addr1), .n_rounds(n_rounds),
    .softreg_req_valid(softreg_req_valid), .softreg_req_isWrite(softreg_req_isWrite),
    .softreg_req_addr(softreg_req_addr), .softreg_req_data(softreg_req_data),
    .softreg_resp_valid(softreg_resp_valid), .softreg_resp_data(softreg_resp_data),
    .busy(busy), .done(done), .error(error), .result(result), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // Cycle index: value seen at the falling edge inside cycle k is k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic        w;
    logic [31:0] a;
    logic [63:0] d;
  } req_t;

  req_t log_q[$];
  int   bad_idle = 0;

  always @(negedge clk) begin
    if (rst && softreg_req_valid)
      log_q.push_back('{cyc, softreg_req_isWrite, softreg_req_addr, softreg_req_data});
    if (!softreg_req_valid && (softreg_req_isWrite || softreg_req_addr != 32'd0 || softreg_req_data != 64'd0))
      bad_idle++;
  end

  int          errors = 0;
  int          checks = 0;
  logic [63:0] prm  [7];
  logic [31:0] amap [8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_params(input bit inv);
    n_vert      = inv ? ~prm[0] : prm[0];
    n_inedges   = inv ? ~prm[1] : prm[1];
    vaddr       = inv ? ~prm[2] : prm[2];
    ieaddr      = inv ? ~prm[3] : prm[3];
    write_addr0 = inv ? ~prm[4] : prm[4];
    write_addr1 = inv ? ~prm[5] : prm[5];
    n_rounds    = inv ? ~prm[6] : prm[6];
  endtask

  task automatic rand_params();
    for (int i = 0; i < 7; i++) prm[i] = {$urandom, $urandom};
  endtask

  task automatic check_outputs_zero(input string tg);
    check({tg, "_valid"},  64'(softreg_req_valid), 64'd0);
    check({tg, "_iswr"},   64'(softreg_req_isWrite), 64'd0);
    check({tg, "_addr"},   64'(softreg_req_addr), 64'd0);
    check({tg, "_data"},   softreg_req_data, 64'd0);
    check({tg, "_busy"},   64'(busy), 64'd0);
    check({tg, "_done"},   64'(done), 64'd0);
    check({tg, "_error"},  64'(error), 64'd0);
    check({tg, "_result"}, result, 64'd0);
    check({tg, "_cycles"}, 64'(cycles), 64'd0);
  endtask

  // Runs one job. The responder answers read number k (1-based, 0 = never) d cycles after it
  // appears. Optional stray response and second start at fixed offsets from the start cycle.
  task automatic job(input string tg, input int k, input int d, input logic [63:0] rdat,
                     input int stray_off, input int restart_off);
    int          base, s, target, nr, exp_n, rfirst, exp_cyc;
    bit          fin, succ;
    logic [63:0] ed;
    req_t        e;
    base = log_q.size();
    @(negedge clk);
    drive_params(1'b0);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start  = 1'b0;
    target = -1;
    nr     = 0;
    fin    = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i > 0) @(negedge clk);
      if (softreg_req_valid && !softreg_req_isWrite) begin
        nr++;
        if (nr == k) target = cyc + d;
      end
      softreg_resp_valid = (cyc == target) || (cyc == s + stray_off);
      softreg_resp_data  = (cyc == target) ? rdat : 64'hDEAD_BEEF_0BAD_F00D;
      start = (cyc == s + restart_off);
      if (start) drive_params(1'b1);
      if (!busy) begin
        fin = 1'b1;
        break;
      end
    end
    @(negedge clk);
    softreg_resp_valid = 1'b0;
    softreg_resp_data  = 64'd0;
    start              = 1'b0;
    repeat (3) @(negedge clk);

    // Reference: a response in the 1..T-1 cycles after a read is accepted; otherwise the
    // read times out, and after MR reissues the job fails.
    succ    = (k >= 1) && (k <= MR + 1) && (d >= 1) && (d <= T - 1);
    exp_n   = succ ? k : MR + 1;
    rfirst  = s + 8 + PD + 1;
    exp_cyc = succ ? (rfirst + (k - 1) * (T + 1) + d - s)
                   : (rfirst + MR * (T + 1) + (T - 1) - s);

    check({tg, "_finished"}, 64'(fin), 64'd1);
    check({tg, "_nreq"}, 64'(log_q.size() - base), 64'(8 + exp_n));
    if (log_q.size() >= base + 8 + exp_n) begin
      for (int i = 0; i < 8; i++) begin
        e  = log_q[base + i];
        ed = (i < 7) ? prm[i] : 64'd0;
        check($sformatf("%s_wr%0d_iswr", tg, i), 64'(e.w), 64'd1);
        check($sformatf("%s_wr%0d_addr", tg, i), 64'(e.a), 64'(amap[i]));
        check($sformatf("%s_wr%0d_data", tg, i), e.d, ed);
        check($sformatf("%s_wr%0d_cyc", tg, i), 64'(e.c), 64'(s + 1 + i));
      end
      for (int j = 0; j < exp_n; j++) begin
        e = log_q[base + 8 + j];
        check($sformatf("%s_rd%0d_iswr", tg, j), 64'(e.w), 64'd0);
        check($sformatf("%s_rd%0d_addr", tg, j), 64'(e.a), 64'(A_DONE_ALL));
        check($sformatf("%s_rd%0d_data", tg, j), e.d, 64'd0);
        check($sformatf("%s_rd%0d_cyc", tg, j), 64'(e.c), 64'(rfirst + j * (T + 1)));
      end
    end
    check({tg, "_busy"},   64'(busy), 64'd0);
    check({tg, "_done"},   64'(done), 64'(succ));
    check({tg, "_error"},  64'(error), 64'(!succ));
    check({tg, "_result"}, result, succ ? rdat : 64'd0);
    check({tg, "_cycles"}, 64'(cycles), 64'(exp_cyc));
    check({tg, "_idle_zero"}, 64'(bad_idle), 64'd0);
  endtask

  initial begin
    int          n0;
    bit          found;
    logic [63:0] rd, last;

    amap[0] = 32'h00; amap[1] = 32'h08; amap[2] = 32'h10; amap[3] = 32'h18;
    amap[4] = 32'h20; amap[5] = 32'h28; amap[6] = 32'h30; amap[7] = 32'h38;

    rst                = 1'b0;
    start              = 1'b0;
    softreg_resp_valid = 1'b0;
    softreg_resp_data  = 64'd0;
    for (int i = 0; i < 7; i++) prm[i] = 64'd0;
    drive_params(1'b0);

    // Reset state.
    @(negedge clk);
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Nominal job.
    prm[0] = 64'd1000;  prm[1] = 64'd5441;  prm[2] = 64'd0;  prm[3] = 64'd16000;
    prm[4] = 64'd59528; prm[5] = 64'd67528; prm[6] = 64'd4;
    job("nominal", 1, 5, 64'h1234, -1, -1);

    // Stray response in IDLE is ignored.
    n0 = log_q.size();
    @(negedge clk);
    softreg_resp_valid = 1'b1;
    softreg_resp_data  = 64'h5555_AAAA_5555_AAAA;
    @(negedge clk);
    softreg_resp_valid = 1'b0;
    softreg_resp_data  = 64'd0;
    repeat (2) @(negedge clk);
    check("idle_stray_result", result, 64'h1234);
    check("idle_stray_done", 64'(done), 64'd1);
    check("idle_stray_busy", 64'(busy), 64'd0);
    check("idle_stray_nreq", 64'(log_q.size() - n0), 64'd0);

    // Never respond: four reads then error.
    rand_params();
    job("timeout", 0, 1, 64'd0, -1, -1);

    // Respond only after the third read.
    rand_params();
    rd = {$urandom, $urandom};
    job("late", 3, int'($urandom_range(1, T - 2)), rd, -1, -1);

    // Response on the exact timeout cycle wins.
    rand_params();
    rd = {$urandom, $urandom};
    job("simul", 2, T - 1, rd, -1, -1);

    // Response one cycle after timeout lands in the reissue cycle and is ignored.
    rand_params();
    job("late_stray", 1, T, 64'h77, -1, -1);

    // Start while busy and a stray response during the writes.
    rand_params();
    rd = {$urandom, $urandom};
    job("busy_start", 1, int'($urandom_range(1, T - 1)), rd, 3, 4);

    // Reset in the middle of the write burst.
    rand_params();
    @(negedge clk);
    drive_params(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (softreg_req_valid && softreg_req_addr == A_IEADDR) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mid_rst_found_idx3", 64'(found), 64'd1);
    rst = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    rand_params();
    rd = {$urandom, $urandom};
    job("after_rst", 1, 4, rd, -1, -1);

    // Randomised jobs.
    last = 64'd0;
    for (int it = 0; it < 4; it++) begin
      rand_params();
      rd = {$urandom, $urandom};
      job($sformatf("rnd%0d", it), int'($urandom_range(0, 4)), int'($urandom_range(1, T)), rd, -1, -1);
      last = rd;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
